spi_accel_poller: RTL and testbench

SPI master that reads the X and Y acceleration bytes from the board accelerometer and presents them to the picorv32 system as registered values. It sits between the SoC peripheral bus glue (upstream; it drives start and consumes x_data/y_data) and the off-chip sensor pins MOSI/MISO/SCLK/CS_N (downstream). Each request runs two back-to-back register-read frames: command RD_CMD then address X_ADDR, and command RD_CMD then address Y_ADDR.

---
 rtl/spi_accel_poller.sv | 193 +++++++++++++++++++
 tb/tb_spi_accel_poller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_accel_poller.sv
// SPI mode-0 master that reads the accelerometer X and Y bytes as two 24-bit register-read frames.
// Optional `ACCEL_AUTO_POLL_EN: self-triggered polling every POLL_CYCLES idle cycles.
module spi_accel_poller #(
    parameter int unsigned CLK_DIV     = 4,
    parameter logic [7:0]  RD_CMD      = 8'h0B,
    parameter logic [7:0]  X_ADDR      = 8'h08,
    parameter logic [7:0]  Y_ADDR      = 8'h09,
    parameter int unsigned POLL_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    output logic       busy,
    output logic [7:0] x_data,
    output logic [7:0] y_data,
    output logic       data_valid,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    localparam int unsigned CW = $clog2(2 * CLK_DIV) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] RISE_CNT  = CW'(CLK_DIV);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic          y_frame_q, y_frame_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    x_buf_q, x_buf_d;
    logic [7:0]    x_data_q, x_data_d;
    logic [7:0]    y_data_q, y_data_d;
    logic [23:0]   frame;
    logic          go;

`ifdef ACCEL_AUTO_POLL_EN
    localparam int unsigned PW = $clog2(POLL_CYCLES);
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;

    assign go = start || (poll_cnt_q == PW'(POLL_CYCLES - 1));

    // Held at zero while busy so it restarts from 0 on entering IDLE.
    always_comb begin
        poll_cnt_d = poll_cnt_q + 1'b1;
        if (state_q != S_IDLE || go) begin
            poll_cnt_d = '0;
        end
    end

    // Reset value makes the first poll launch one cycle after reset release.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            poll_cnt_q <= PW'(POLL_CYCLES - 2);
        end else begin
            poll_cnt_q <= poll_cnt_d;
        end
    end
`else
    assign go = start;
`endif

    assign frame = {RD_CMD, (y_frame_q ? Y_ADDR : X_ADDR), 8'h00};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        y_frame_d = y_frame_q;
        rx_d      = rx_q;
        x_buf_d   = x_buf_q;
        x_data_d  = x_data_q;
        y_data_d  = y_data_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d   = S_SETUP;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    y_frame_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // Only the final byte of the frame carries sensor data.
                if (cnt_q == RISE_CNT && bit_cnt_q >= 5'd16) begin
                    rx_d = {rx_q[6:0], miso};
                end
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 5'd23) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (y_frame_q) begin
                        state_d  = S_DONE;
                        x_data_d = x_buf_q;
                        y_data_d = rx_q;
                    end else begin
                        state_d = S_GAP;
                        x_buf_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == FULL_LAST) begin
                    state_d   = S_SETUP;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    y_frame_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            y_frame_q <= 1'b0;
            rx_q      <= '0;
            x_buf_q   <= '0;
            x_data_q  <= '0;
            y_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            y_frame_q <= y_frame_d;
            rx_q      <= rx_d;
            x_buf_q   <= x_buf_d;
            x_data_q  <= x_data_d;
            y_data_q  <= y_data_d;
        end
    end

    always_comb begin
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        if (state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD) begin
            cs_n = 1'b0;
        end
        if (state_q == S_SHIFT && cnt_q >= RISE_CNT) begin
            sclk = 1'b1;
        end
        // Bit counter is 0 in SETUP, so the MSB is already on mosi when cs_n falls.
        if (state_q == S_SETUP || state_q == S_SHIFT) begin
            mosi = frame[5'd23 - bit_cnt_q];
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign data_valid = (state_q == S_DONE);
    assign x_data     = x_data_q;
    assign y_data     = y_data_q;

endmodule

// File: tb/tb_spi_accel_poller.sv
// Self-checking bench for spi_accel_poller: address-decoding sensor model, frame monitor, scoreboard.
// With ACCEL_AUTO_POLL_EN defined only the autonomous poll spacing is exercised.
module tb_spi_accel_poller;

    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned POLL      = 50;
    localparam logic [7:0]  RD_CMD    = 8'h0B;
    localparam logic [7:0]  X_ADDR    = 8'h08;
    localparam logic [7:0]  Y_ADDR    = 8'h09;
    localparam int unsigned FRAME_LOW = 50 * CLK_DIV;
    localparam int unsigned GAP_HIGH  = 2 * CLK_DIV;
    localparam int unsigned LATENCY   = 102 * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       miso = 1'b0;
    logic       busy, data_valid, sclk, mosi, cs_n;
    logic [7:0] x_data, y_data;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    spi_accel_poller #(
        .CLK_DIV    (CLK_DIV),
        .RD_CMD     (RD_CMD),
        .X_ADDR     (X_ADDR),
        .Y_ADDR     (Y_ADDR),
        .POLL_CYCLES(POLL)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .busy      (busy),
        .x_data    (x_data),
        .y_data    (y_data),
        .data_valid(data_valid),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .cs_n      (cs_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sensor model: decodes the address from mosi, answers in the last byte, junk elsewhere.
    int         miso_mode = 0;  // 0 answer by address, 1 all ones, 2 all zeros
    logic [7:0] x_val = 8'h00;
    logic [7:0] y_val = 8'h00;
    logic [7:0] s_addr = 8'h00;
    logic [23:0] s_sh = 24'h0;
    int         s_rise = 0;
    int         s_fall = 0;
    logic       s_prev_sclk = 1'b0;
    logic [23:0] mosi_q[$];

    function automatic logic resp_bit(input int k);
        logic [7:0] b;
        if (miso_mode == 1) return 1'b1;
        if (miso_mode == 2) return 1'b0;
        if (k < 16 || k > 23) return 1'($urandom);
        b = (s_addr == X_ADDR) ? x_val : (s_addr == Y_ADDR) ? y_val : 8'h00;
        return b[23 - k];
    endfunction

    always @(negedge clk) begin
        if (cs_n) begin
            s_rise = 0;
            s_fall = 0;
            miso = resp_bit(0);
        end else begin
            if (sclk && !s_prev_sclk) begin
                s_sh = {s_sh[22:0], mosi};
                s_rise++;
                if (s_rise == 16) s_addr = s_sh[7:0];
                if (s_rise == 24) mosi_q.push_back(s_sh);
            end
            if (!sclk && s_prev_sclk) s_fall++;
            if (!sclk) miso = resp_bit(s_fall);
        end
        s_prev_sclk = sclk;
    end

    // Frame monitor: chip-select run lengths, idle sclk, data_valid pulses.
    int   cs_falls = 0;
    int   dv_count = 0;
    int   sclk_viol = 0;
    int   low_len = 0;
    int   high_len = 0;
    int   gap_len = 0;
    logic cs_prev = 1'b1;
    int   low_q[$];
    int   dv_cyc_q[$];

    always @(negedge clk) begin
        if (cs_n && sclk) sclk_viol++;
        if (!cs_n && cs_prev) begin
            cs_falls++;
            if (cs_falls == 2) gap_len = high_len;
            low_len = 1;
        end else if (cs_n && !cs_prev) begin
            low_q.push_back(low_len);
            high_len = 1;
        end else if (cs_n) begin
            high_len++;
        end else begin
            low_len++;
        end
        if (data_valid) begin
            dv_count++;
            dv_cyc_q.push_back(cyc);
        end
        cs_prev = cs_n;
    end

    task automatic run_poll(input string tag, input int mode, input logic [7:0] xv,
                            input logic [7:0] yv, input bit extra);
        logic [7:0] ex, ey, gx, gy;
        int dv_k;
        @(negedge clk);
        miso_mode = mode;
        x_val = xv;
        y_val = yv;
        ex = (mode == 1) ? 8'hFF : (mode == 2) ? 8'h00 : xv;
        ey = (mode == 1) ? 8'hFF : (mode == 2) ? 8'h00 : yv;
        cs_falls = 0;
        dv_count = 0;
        sclk_viol = 0;
        gap_len = 0;
        low_q.delete();
        mosi_q.delete();
        start = 1'b1;
        dv_k = -1;
        gx = 8'h00;
        gy = 8'h00;
        for (int k = 1; k <= 230; k++) begin
            @(negedge clk);
            start = extra && (k == 10 || k == 150 || k == int'(LATENCY));
            if (k == 1) check($sformatf("%s.busy_on", tag), busy, 1);
            if (dv_k > 0 && k == dv_k + 1) check($sformatf("%s.busy_off", tag), busy, 0);
            if (data_valid && dv_k < 0) begin
                dv_k = k;
                gx = x_data;
                gy = y_data;
            end
        end
        check($sformatf("%s.dv_cycle", tag), dv_k, LATENCY);
        check($sformatf("%s.dv_count", tag), dv_count, 1);
        check($sformatf("%s.x", tag), gx, ex);
        check($sformatf("%s.y", tag), gy, ey);
        check($sformatf("%s.x_hold", tag), x_data, ex);
        check($sformatf("%s.y_hold", tag), y_data, ey);
        check($sformatf("%s.cs_falls", tag), cs_falls, 2);
        check($sformatf("%s.frames", tag), low_q.size(), 2);
        foreach (low_q[i]) check($sformatf("%s.cs_low%0d", tag, i), low_q[i], FRAME_LOW);
        check($sformatf("%s.gap", tag), gap_len, GAP_HIGH);
        check($sformatf("%s.sclk_idle", tag), sclk_viol, 0);
        check($sformatf("%s.mosi_words", tag), mosi_q.size(), 2);
        if (mosi_q.size() == 2) begin
            check($sformatf("%s.mosi_x", tag), mosi_q[0], {RD_CMD, X_ADDR, 8'h00});
            check($sformatf("%s.mosi_y", tag), mosi_q[1], {RD_CMD, Y_ADDR, 8'h00});
        end
    endtask

    // Y frame bit b occupies cycles 53*CLK_DIV+1+2*CLK_DIV*b onward; hit the low half of bit 12.
    task automatic reset_mid_y();
        @(negedge clk);
        miso_mode = 0;
        x_val = 8'($urandom);
        y_val = 8'($urandom);
        start = 1'b1;
        for (int k = 1; k <= int'(53 * CLK_DIV + 1 + 24 * CLK_DIV); k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("rst_mid.in_frame", cs_n, 0);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_mid.cs_n", cs_n, 1);
        check("rst_mid.sclk", sclk, 0);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.x", x_data, 0);
        check("rst_mid.y", y_data, 0);
        check("rst_mid.dv", data_valid, 0);
        dv_count = 0;
        resetn = 1'b1;
        repeat (300) @(negedge clk);
        check("rst_mid.no_dv", dv_count, 0);
        check("rst_mid.idle", cs_n, 1);
    endtask

`ifndef ACCEL_AUTO_POLL_EN
    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.cs_n", cs_n, 1);
        check("rst.sclk", sclk, 0);
        check("rst.mosi", mosi, 0);
        check("rst.busy", busy, 0);
        check("rst.dv", data_valid, 0);
        check("rst.x", x_data, 0);
        check("rst.y", y_data, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check("idle.no_poll", cs_falls, 0);
        run_poll("basic", 0, 8'hA5, 8'h3C, 1'b0);
        run_poll("restart", 0, 8'($urandom), 8'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) begin
            run_poll($sformatf("rand%0d", i), 0, 8'($urandom), 8'($urandom), 1'b0);
        end
        run_poll("ones", 1, 8'h00, 8'h00, 1'b0);
        run_poll("zeros", 2, 8'hFF, 8'hFF, 1'b0);
        reset_mid_y();
        run_poll("fresh", 0, 8'($urandom), 8'($urandom), 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
`else
    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.cs_n", cs_n, 1);
        check("rst.dv", data_valid, 0);
        miso_mode = 0;
        x_val = 8'($urandom);
        y_val = 8'($urandom);
        dv_cyc_q.delete();
        resetn = 1'b1;
        repeat (1200) @(negedge clk);
        check("auto.pulses", dv_cyc_q.size() >= 4, 1);
        for (int i = 1; i < dv_cyc_q.size(); i++) begin
            check($sformatf("auto.spacing%0d", i), dv_cyc_q[i] - dv_cyc_q[i-1], LATENCY + POLL);
        end
        check("auto.x", x_data, x_val);
        check("auto.y", y_data, y_val);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
`endif

endmodule
